// File: rtl/char_renderer.sv
// ---------------------------------------------------------------------------
// char_renderer
// Renders one scanline of a text-mode display into a pixel buffer. For each
// of COLS character cells it fetches the {attribute, code} pair from the
// character row buffer, the glyph row from the font ROM, and the foreground
// and background colours from the palette. It then writes GLYPH_W pixels.
// Each cell takes 13 cycles. A line ends with a one-cycle done pulse.
//
// Ports
//   clk               pixel-domain clock, rising edge
//   rst               asynchronous, active-high reset
//   start             render request, honoured only while idle
//   glyph_row         font row within the character row, latched on start
//   busy              high whenever the block is not idle
//   done              one-cycle pulse in the final cycle of a line
//   chrowbuf_rd/_addr/_data  character row buffer read port (strobe active low)
//   font_rd/_addr/_data      font ROM read port (strobe active low)
//   palette_rd/_addr/_data   palette read port (strobe active low)
//   pixbuf_wr/_addr/_data    pixel buffer write port (strobe active low)
//
// Every output is a register. The combinational block therefore computes the
// value each output must hold in the *next* state. The register then presents
// that value for the whole cycle in which the state is current.
// ---------------------------------------------------------------------------
module char_renderer #(
    parameter int COLS    = 100,
    parameter int GLYPH_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  glyph_row,
    output logic        busy,
    output logic        done,
    output logic        chrowbuf_rd,
    output logic [7:0]  chrowbuf_rd_addr,
    input  logic [15:0] chrowbuf_rd_data,
    output logic        font_rd,
    output logic [11:0] font_rd_addr,
    input  logic [7:0]  font_rd_data,
    output logic        palette_rd,
    output logic [7:0]  palette_rd_addr,
    input  logic [15:0] palette_rd_data,
    output logic        pixbuf_wr,
    output logic [9:0]  pixbuf_wr_addr,
    output logic [15:0] pixbuf_wr_data
);

    localparam int PIX_W = $clog2(GLYPH_W);
    // The pixel address is {col, pix}. That equals col*GLYPH_W + pix because
    // GLYPH_W is a power of two, so col takes the rest of the 10-bit x range.
    localparam int COL_W = 10 - PIX_W;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(GLYPH_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ_CHR,
        WAIT_CHR,
        REQ_FNT,
        REQ_BG,
        WAIT_BG,
        WRITE,
        DONE
    } state_t;

    state_t state, state_n;

    logic [COL_W-1:0] col, col_n;
    logic [PIX_W-1:0] pix, pix_n;
    logic [3:0]       row, row_n;
    logic [3:0]       bg_idx, bg_idx_n;
    logic [7:0]       glyph, glyph_n;
    logic [15:0]      fg, fg_n;
    logic [15:0]      bg, bg_n;

    logic             busy_n, done_n;
    logic             chr_rd_n, font_rd_n, pal_rd_n, wr_n;
    logic [7:0]       chr_addr_n, pal_addr_n;
    logic [11:0]      font_addr_n;
    logic [9:0]       wr_addr_n;
    logic [15:0]      wr_data_n;

    // State register. A reset abandons any line in progress immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-output logic. Strobes default to inactive. Addresses
    // and datapath registers default to holding their value.
    //
    // Memory data appears one cycle after its strobe. That fixes when each
    // value is picked up:
    //   - The character word arrives in WAIT_CHR. The font address and the
    //     foreground palette address are built straight from it.
    //   - The glyph and the foreground colour arrive together in REQ_BG.
    //   - The background colour arrives in WAIT_BG. The first pixel therefore
    //     uses the live palette data, not the bg register.
    always_comb begin
        state_n     = state;
        col_n       = col;
        pix_n       = pix;
        row_n       = row;
        bg_idx_n    = bg_idx;
        glyph_n     = glyph;
        fg_n        = fg;
        bg_n        = bg;
        done_n      = 1'b0;
        chr_rd_n    = 1'b1;
        chr_addr_n  = chrowbuf_rd_addr;
        font_rd_n   = 1'b1;
        font_addr_n = font_rd_addr;
        pal_rd_n    = 1'b1;
        pal_addr_n  = palette_rd_addr;
        wr_n        = 1'b1;
        wr_addr_n   = pixbuf_wr_addr;
        wr_data_n   = pixbuf_wr_data;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n    = REQ_CHR;
                    row_n      = glyph_row;
                    col_n      = '0;
                    chr_rd_n   = 1'b0;
                    chr_addr_n = 8'h00;
                end
            end
            REQ_CHR: begin
                state_n = WAIT_CHR;
            end
            WAIT_CHR: begin
                state_n     = REQ_FNT;
                bg_idx_n    = chrowbuf_rd_data[15:12];
                font_rd_n   = 1'b0;
                font_addr_n = {chrowbuf_rd_data[7:0], row};
                pal_rd_n    = 1'b0;
                pal_addr_n  = {4'h0, chrowbuf_rd_data[11:8]};
            end
            REQ_FNT: begin
                state_n    = REQ_BG;
                pal_rd_n   = 1'b0;
                pal_addr_n = {4'h0, bg_idx};
            end
            REQ_BG: begin
                state_n = WAIT_BG;
                glyph_n = font_rd_data;
                fg_n    = palette_rd_data;
            end
            WAIT_BG: begin
                state_n   = WRITE;
                bg_n      = palette_rd_data;
                pix_n     = '0;
                wr_n      = 1'b0;
                wr_addr_n = {col, PIX_W'(0)};
                wr_data_n = glyph[LAST_PIX] ? fg : palette_rd_data;
            end
            WRITE: begin
                if (pix == LAST_PIX) begin
                    if (col == LAST_COL) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n    = REQ_CHR;
                        col_n      = col + COL_W'(1);
                        chr_rd_n   = 1'b0;
                        chr_addr_n = 8'(col_n);
                    end
                end else begin
                    pix_n     = pix + PIX_W'(1);
                    wr_n      = 1'b0;
                    wr_addr_n = {col, pix_n};
                    wr_data_n = glyph[LAST_PIX - pix_n] ? fg : bg;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // Datapath and output registers. Strobes reset to their inactive high
    // level. Everything else resets to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col              <= '0;
            pix              <= '0;
            row              <= '0;
            bg_idx           <= '0;
            glyph            <= '0;
            fg               <= '0;
            bg               <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            chrowbuf_rd      <= 1'b1;
            chrowbuf_rd_addr <= '0;
            font_rd          <= 1'b1;
            font_rd_addr     <= '0;
            palette_rd       <= 1'b1;
            palette_rd_addr  <= '0;
            pixbuf_wr        <= 1'b1;
            pixbuf_wr_addr   <= '0;
            pixbuf_wr_data   <= '0;
        end else begin
            col              <= col_n;
            pix              <= pix_n;
            row              <= row_n;
            bg_idx           <= bg_idx_n;
            glyph            <= glyph_n;
            fg               <= fg_n;
            bg               <= bg_n;
            busy             <= busy_n;
            done             <= done_n;
            chrowbuf_rd      <= chr_rd_n;
            chrowbuf_rd_addr <= chr_addr_n;
            font_rd          <= font_rd_n;
            font_rd_addr     <= font_addr_n;
            palette_rd       <= pal_rd_n;
            palette_rd_addr  <= pal_addr_n;
            pixbuf_wr        <= wr_n;
            pixbuf_wr_addr   <= wr_addr_n;
            pixbuf_wr_data   <= wr_data_n;
        end
    end

endmodule

// File: tb/tb_char_renderer.sv
// ---------------------------------------------------------------------------
// tb_char_renderer
// Self-checking bench for char_renderer. It models the row buffer, font ROM
// and palette as arrays that answer one cycle after each read strobe. It
// records every pixel write and checks the whole line against a per-pixel
// formula computed directly from the array contents.
// ---------------------------------------------------------------------------
module tb_char_renderer;

    localparam int COLS = 100;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  glyph_row;
    logic        busy;
    logic        done;
    logic        chrowbuf_rd;
    logic [7:0]  chrowbuf_rd_addr;
    logic [15:0] chrowbuf_rd_data;
    logic        font_rd;
    logic [11:0] font_rd_addr;
    logic [7:0]  font_rd_data;
    logic        palette_rd;
    logic [7:0]  palette_rd_addr;
    logic [15:0] palette_rd_data;
    logic        pixbuf_wr;
    logic [9:0]  pixbuf_wr_addr;
    logic [15:0] pixbuf_wr_data;

    logic [15:0] chrow_mem [256];
    logic [7:0]  font_mem  [4096];
    logic [15:0] pal_mem   [256];

    logic [25:0] wr_q[$];
    logic [7:0]  chr_q[$];
    int          chr_cyc_q[$];
    logic [3:0]  fnt_q[$];
    int          done_q[$];
    int          cyc;

    int wr_base, chr_base, fnt_base, done_base;
    int tests;
    int failed;

    char_renderer #(.COLS(COLS), .GLYPH_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .glyph_row        (glyph_row),
        .busy             (busy),
        .done             (done),
        .chrowbuf_rd      (chrowbuf_rd),
        .chrowbuf_rd_addr (chrowbuf_rd_addr),
        .chrowbuf_rd_data (chrowbuf_rd_data),
        .font_rd          (font_rd),
        .font_rd_addr     (font_rd_addr),
        .font_rd_data     (font_rd_data),
        .palette_rd       (palette_rd),
        .palette_rd_addr  (palette_rd_addr),
        .palette_rd_data  (palette_rd_data),
        .pixbuf_wr        (pixbuf_wr),
        .pixbuf_wr_addr   (pixbuf_wr_addr),
        .pixbuf_wr_data   (pixbuf_wr_data)
    );

    // Free-running pixel clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memories with one cycle of read latency. A strobe and address seen at
    // an edge produce data for the following cycle.
    always @(posedge clk) begin
        if (!chrowbuf_rd) chrowbuf_rd_data <= chrow_mem[chrowbuf_rd_addr];
        if (!font_rd)     font_rd_data     <= font_mem[font_rd_addr];
        if (!palette_rd)  palette_rd_data  <= pal_mem[palette_rd_addr];
    end

    // Mid-cycle monitor. It only ever appends to the logs. Each check works
    // from base indices taken when its line starts.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!pixbuf_wr) wr_q.push_back({pixbuf_wr_addr, pixbuf_wr_data});
        if (!chrowbuf_rd) begin
            chr_q.push_back(chrowbuf_rd_addr);
            chr_cyc_q.push_back(cyc);
        end
        if (!font_rd) fnt_q.push_back(font_rd_addr[3:0]);
        if (done) done_q.push_back(cyc);
    end

    // Single comparison point. It counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic markBases();
        wr_base   = wr_q.size();
        chr_base  = chr_q.size();
        fnt_base  = fnt_q.size();
        done_base = done_q.size();
    endtask

    // Drives a one-cycle start pulse. On return it is #1 into the cycle that
    // follows the accepting edge, which is the first REQ_CHR cycle.
    task automatic applyStimulus(input logic [3:0] row);
        @(posedge clk);
        #1 start = 1'b1;
        glyph_row = row;
        @(posedge clk);
        #1 start = 1'b0;
        glyph_row = 4'($urandom);
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (done_q.size() == done_base && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (done_q.size() == done_base) checkOutput({tag, " done_timeout"}, 32'd0, 32'd1);
    endtask

    // Reference for a whole line. Pixel x = c*8+p takes the foreground colour
    // when bit (7-p) of the glyph for cell c is set, otherwise the background.
    task automatic checkLine(input logic [3:0] row, input string tag);
        logic [15:0] cw, fgc, bgc, e;
        logic [7:0]  g;
        int          idx, bad, f0, row_err;
        checkOutput({tag, " write_count"}, 32'(wr_q.size() - wr_base), 32'(COLS * 8));
        bad = 0;
        for (int c = 0; c < COLS; c++) begin
            cw  = chrow_mem[c];
            g   = font_mem[{cw[7:0], row}];
            fgc = pal_mem[{4'h0, cw[11:8]}];
            bgc = pal_mem[{4'h0, cw[15:12]}];
            for (int p = 0; p < 8; p++) begin
                idx = c * 8 + p;
                if (bad == 0 && wr_base + idx < wr_q.size()) begin
                    e  = g[7 - p] ? fgc : bgc;
                    f0 = failed;
                    checkOutput({tag, " pixel"}, 32'(wr_q[wr_base + idx]), {6'd0, 10'(idx), e});
                    if (failed != f0) bad = 1;
                end
            end
        end
        checkOutput({tag, " chr_reads"}, 32'(chr_q.size() - chr_base), 32'(COLS));
        if (chr_q.size() > chr_base)
            checkOutput({tag, " last_chr_addr"}, 32'(chr_q[chr_q.size() - 1]), 32'(COLS - 1));
        checkOutput({tag, " done_pulses"}, 32'(done_q.size() - done_base), 32'd1);
        if (done_q.size() > done_base && chr_cyc_q.size() > chr_base)
            checkOutput({tag, " done_cycle"}, 32'(done_q[done_base] - chr_cyc_q[chr_base]), 32'(COLS * 13));
        row_err = 0;
        for (int i = fnt_base; i < fnt_q.size(); i++)
            if (fnt_q[i] !== row) row_err++;
        checkOutput({tag, " font_row_errs"}, 32'(row_err), 32'd0);
    endtask

    task automatic randomMemories();
        for (int i = 0; i < 256; i++) chrow_mem[i] = 16'($urandom);
        for (int i = 0; i < 4096; i++) font_mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) pal_mem[i] = 16'($urandom);
    endtask

    // Stimulus sequence.
    initial begin
        logic [15:0] pat [8];
        logic [3:0]  row;
        int          snap;
        tests = 0;
        failed = 0;
        cyc = 0;
        rst = 1'b1;
        start = 1'b0;
        glyph_row = 4'h0;
        chrowbuf_rd_data = '0;
        font_rd_data = '0;
        palette_rd_data = '0;
        randomMemories();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_strobes", {28'd0, chrowbuf_rd, font_rd, palette_rd, pixbuf_wr}, 32'hF);
        checkOutput("rst_busy_done", {30'd0, busy, done}, 32'd0);
        checkOutput("rst_addrs", {chrowbuf_rd_addr, font_rd_addr, palette_rd_addr, 4'd0}, 32'd0);
        checkOutput("rst_wr", {6'd0, pixbuf_wr_addr, pixbuf_wr_data}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Uniform line: attr 0x1E, code 0x41, glyph 0xA5.
        for (int i = 0; i < 256; i++) chrow_mem[i] = 16'h1E41;
        font_mem[12'h413] = 8'hA5;
        pal_mem[8'h0E] = 16'h0CC0;
        pal_mem[8'h01] = 16'h0005;
        markBases();
        applyStimulus(4'd3);
        checkOutput("uni_busy", {31'd0, busy}, 32'd1);
        waitDone("uni");
        repeat (3) @(negedge clk);
        checkLine(4'd3, "uni");
        pat = '{16'h0CC0, 16'h0005, 16'h0CC0, 16'h0005, 16'h0005, 16'h0CC0, 16'h0005, 16'h0CC0};
        for (int p = 0; p < 8; p++) begin
            if (wr_base + 792 + p < wr_q.size())
                checkOutput("uni_last_cell", 32'(wr_q[wr_base + 792 + p]), {6'd0, 10'(792 + p), pat[p]});
        end

        // Random lines, with an all-background and an all-foreground cell.
        // The second line starts in the cycle right after done.
        for (int l = 0; l < 2; l++) begin
            randomMemories();
            row = 4'($urandom);
            chrow_mem[5] = {chrow_mem[5][15:8], 8'h00};
            chrow_mem[6] = {chrow_mem[6][15:8], 8'h01};
            font_mem[{8'h00, row}] = 8'h00;
            font_mem[{8'h01, row}] = 8'hFF;
            for (int i = 0; i < COLS; i++)
                if (i != 5 && i != 6 && chrow_mem[i][7:1] == 7'd0) chrow_mem[i][7:0] = 8'h02;
            markBases();
            applyStimulus(row);
            if (l == 1) begin
                checkOutput("b2b_chr_rd", {31'd0, chrowbuf_rd}, 32'd0);
                checkOutput("b2b_chr_addr", 32'(chrowbuf_rd_addr), 32'd0);
            end
            waitDone("rnd");
            if (l == 0) begin
                checkLine(row, "rnd");
            end else begin
                repeat (3) @(negedge clk);
                checkLine(row, "rnd_b2b");
            end
            if (wr_base + 55 < wr_q.size()) begin
                checkOutput("glyph00_bg", 32'(wr_q[wr_base + 43][15:0]), 32'(pal_mem[{4'h0, chrow_mem[5][15:12]}]));
                checkOutput("glyphFF_fg", 32'(wr_q[wr_base + 52][15:0]), 32'(pal_mem[{4'h0, chrow_mem[6][11:8]}]));
            end
        end

        // Start pulse and glyph_row change during a render must be ignored.
        repeat (5) @(posedge clk);
        randomMemories();
        row = 4'd3;
        markBases();
        applyStimulus(row);
        repeat (48) @(posedge clk);
        #1 start = 1'b1;
        glyph_row = ~row;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone("mid");
        repeat (30) @(negedge clk);
        checkLine(row, "mid");
        checkOutput("mid_idle_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a line, then a full line after release.
        markBases();
        applyStimulus(4'($urandom));
        repeat (598) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("mrst_strobes", {28'd0, chrowbuf_rd, font_rd, palette_rd, pixbuf_wr}, 32'hF);
        checkOutput("mrst_busy", {31'd0, busy}, 32'd0);
        snap = wr_q.size();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("mrst_no_writes", 32'(wr_q.size() - snap), 32'd0);
        checkOutput("mrst_no_done", 32'(done_q.size() - done_base), 32'd0);
        row = 4'($urandom);
        markBases();
        applyStimulus(row);
        waitDone("post_rst");
        repeat (3) @(negedge clk);
        checkLine(row, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
